// File: rtl/multicycle_control_unit_if.sv
// Memory handshake bundle between the multi-cycle control unit and its
// instruction and data memories. Requests are level signals held until the
// matching ready is seen; no credit accounting, one request in flight per side.
// Ports: imem_req/imem_ready (fetch), dmem_req/dmem_ready with mem_read/mem_write (data).
interface multicycle_control_unit_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_ready;
  logic mem_read;
  logic mem_write;

  modport master (
    output imem_req, dmem_req, mem_read, mem_write,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, mem_read, mem_write,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with trap, timeout, retire counter.
// Latency: CB 3, R/I/LUI/AUIPC/JAL/JALR/S 4, L 5 cycles with zero wait; +1 per memory wait cycle.
// Backpressure: imem_req/dmem_req held until ready; MEM_TIMEOUT waits (0 = never) traps with bus_err.
// Ports: clk, rst (sync, active high), opcode, branch_taken, mem (handshake bundle),
//   datapath controls ir_write/pc_write/PC_src/alu_op/alu_src/reg_write_en/wb_sel,
//   sticky illegal/bus_err flags, retire_count.
// Build option: define CTRL_JUMP_EN to decode JAL/JALR; otherwise they trap as illegal.
`ifndef ALU_OP_LW_SW_type
`define ALU_OP_LW_SW_type 3'b000
`define ALU_OP_CB_type    3'b001
`define ALU_OP_R_type     3'b010
`define ALU_OP_I_type     3'b011
`define ALU_OP_LUI_type   3'b100
`define ALU_OP_AUIPC_type 3'b101
`endif
`ifndef OPCODE_R
`define OPCODE_R     7'b0110011
`define OPCODE_I     7'b0010011
`define OPCODE_L     7'b0000011
`define OPCODE_S     7'b0100011
`define OPCODE_CB    7'b1100011
`define OPCODE_LUI   7'b0110111
`define OPCODE_AUIPC 7'b0010111
`define OPCODE_JAL   7'b1101111
`define OPCODE_JALR  7'b1100111
`endif

module multicycle_control_unit #(
  parameter int OPCODE_W    = 7,
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 branch_taken,
  multicycle_control_unit_if.master mem,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 PC_src,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic                 alu_src,
  output logic                 reg_write_en,
  output logic [1:0]           wb_sel,
  output logic                 illegal,
  output logic                 bus_err,
  output logic [CNT_W-1:0]     retire_count
);

  localparam int WCW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_e;
  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_L, CLS_S, CLS_CB, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BAD
  } cls_e;

  state_e              state, state_n;
  logic [OPCODE_W-1:0] opcode_q;
  logic [WCW-1:0]      wait_cnt;
  logic                illegal_q, bus_err_q;
  logic [CNT_W-1:0]    retire_q;
  logic                retire, set_illegal, set_bus_err, timeout_hit;
  cls_e                cls_in, cls_q;

  function automatic cls_e classify(input logic [OPCODE_W-1:0] op);
    case (op)
      OPCODE_W'(`OPCODE_R):     return CLS_R;
      OPCODE_W'(`OPCODE_I):     return CLS_I;
      OPCODE_W'(`OPCODE_L):     return CLS_L;
      OPCODE_W'(`OPCODE_S):     return CLS_S;
      OPCODE_W'(`OPCODE_CB):    return CLS_CB;
      OPCODE_W'(`OPCODE_LUI):   return CLS_LUI;
      OPCODE_W'(`OPCODE_AUIPC): return CLS_AUIPC;
`ifdef CTRL_JUMP_EN
      OPCODE_W'(`OPCODE_JAL):   return CLS_JAL;
      OPCODE_W'(`OPCODE_JALR):  return CLS_JALR;
`endif
      default:                  return CLS_BAD;
    endcase
  endfunction

  assign cls_in = classify(opcode);
  assign cls_q  = classify(opcode_q);

  // The registered count equals the number of wait cycles already spent, so a
  // ready arriving with the count at MEM_TIMEOUT still completes the access.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WCW'(MEM_TIMEOUT));

  always_comb begin
    state_n       = state;
    mem.imem_req  = 1'b0;
    mem.dmem_req  = 1'b0;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    PC_src        = 1'b0;
    alu_op        = '0;
    alu_src       = 1'b0;
    reg_write_en  = 1'b0;
    wb_sel        = 2'b00;
    retire        = 1'b0;
    set_illegal   = 1'b0;
    set_bus_err   = 1'b0;

    // Datapath class controls follow the latched opcode through EXEC/MEM/WB.
    if (state == EXEC || state == MEM || state == WB) begin
      case (cls_q)
        CLS_R:           alu_op = ALU_OP_W'(`ALU_OP_R_type);
        CLS_I, CLS_JALR: alu_op = ALU_OP_W'(`ALU_OP_I_type);
        CLS_L, CLS_S:    alu_op = ALU_OP_W'(`ALU_OP_LW_SW_type);
        CLS_CB:          alu_op = ALU_OP_W'(`ALU_OP_CB_type);
        CLS_LUI:         alu_op = ALU_OP_W'(`ALU_OP_LUI_type);
        default:         alu_op = ALU_OP_W'(`ALU_OP_AUIPC_type);
      endcase
      alu_src = !(cls_q == CLS_R || cls_q == CLS_CB);
      if (cls_q == CLS_L)                            wb_sel = 2'b01;
      else if (cls_q == CLS_JAL || cls_q == CLS_JALR) wb_sel = 2'b10;
    end

    case (state)
      FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ready) begin
          ir_write = 1'b1;
          state_n  = DECODE;
        end else if (timeout_hit) begin
          set_bus_err = 1'b1;
          state_n     = TRAP;
        end
      end
      DECODE: begin
        if (cls_in == CLS_BAD) begin
          set_illegal = 1'b1;
          state_n     = TRAP;
        end else begin
          state_n = EXEC;
        end
      end
      EXEC: begin
        if (cls_q == CLS_CB) begin
          pc_write = 1'b1;
          PC_src   = branch_taken;
          retire   = 1'b1;
          state_n  = FETCH;
        end else if (cls_q == CLS_L || cls_q == CLS_S) begin
          state_n = MEM;
        end else begin
          state_n = WB;
        end
      end
      MEM: begin
        mem.dmem_req  = 1'b1;
        mem.mem_read  = (cls_q == CLS_L);
        mem.mem_write = (cls_q == CLS_S);
        if (mem.dmem_ready) begin
          if (cls_q == CLS_S) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_n  = FETCH;
          end else begin
            state_n = WB;
          end
        end else if (timeout_hit) begin
          set_bus_err = 1'b1;
          state_n     = TRAP;
        end
      end
      WB: begin
        reg_write_en = 1'b1;
        pc_write     = 1'b1;
        PC_src       = (cls_q == CLS_JAL || cls_q == CLS_JALR);
        retire       = 1'b1;
        state_n      = FETCH;
      end
      default: state_n = TRAP;
    endcase

    // Reset aborts the instruction combinationally: requests drop this cycle.
    if (rst) begin
      state_n       = FETCH;
      mem.imem_req  = 1'b0;
      mem.dmem_req  = 1'b0;
      mem.mem_read  = 1'b0;
      mem.mem_write = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      PC_src        = 1'b0;
      alu_op        = '0;
      alu_src       = 1'b0;
      reg_write_en  = 1'b0;
      wb_sel        = 2'b00;
      retire        = 1'b0;
      set_illegal   = 1'b0;
      set_bus_err   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      opcode_q  <= '0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      retire_q  <= '0;
    end else begin
      state <= state_n;
      if (state == DECODE) opcode_q <= opcode;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus_err) bus_err_q <= 1'b1;
      if (retire) retire_q <= retire_q + CNT_W'(1);
      if ((state_n == FETCH && state != FETCH) || (state_n == MEM && state != MEM))
        wait_cnt <= '0;
      else if (((state == FETCH && !mem.imem_ready) || (state == MEM && !mem.dmem_ready))
               && wait_cnt != {WCW{1'b1}})
        wait_cnt <= wait_cnt + WCW'(1);
    end
  end

  // Registered flags and count read as zero while reset is held.
  assign illegal      = illegal_q & ~rst;
  assign bus_err      = bus_err_q & ~rst;
  assign retire_count = rst ? '0 : retire_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;
  localparam int TO = 15;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011,
                         OP_S = 7'b0100011, OP_CB = 7'b1100011, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                         OP_BAD = 7'b1111111;

  typedef struct packed {
    logic imem_req, dmem_req, ir_write, pc_write, pc_src;
    logic [2:0] alu_op;
    logic alu_src, reg_write_en, mem_read, mem_write;
    logic [1:0] wb_sel;
    logic illegal, bus_err;
    logic [31:0] retire_count;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] opcode = '0;
  logic branch_taken = 1'b0;
  logic ir_write, pc_write, PC_src, alu_src, reg_write_en, illegal, bus_err;
  logic [2:0] alu_op;
  logic [1:0] wb_sel;
  logic [31:0] retire_count;

  multicycle_control_unit_if bus ();

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken), .mem(bus),
    .ir_write(ir_write), .pc_write(pc_write), .PC_src(PC_src), .alu_op(alu_op),
    .alu_src(alu_src), .reg_write_en(reg_write_en), .wb_sel(wb_sel),
    .illegal(illegal), .bus_err(bus_err), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  vec_t exp_q[$];
  int m_ret = 0;
  bit m_ill = 0, m_bus = 0;

  // Instruction classes: 0 R,1 I,2 L,3 S,4 CB,5 LUI,6 AUIPC,7 JAL,8 JALR,-1 illegal.
  function automatic int cls_of(input logic [6:0] op);
    case (op)
      OP_R: return 0;  OP_I: return 1;  OP_L: return 2;  OP_S: return 3;
      OP_CB: return 4; OP_LUI: return 5; OP_AUIPC: return 6;
`ifdef CTRL_JUMP_EN
      OP_JAL: return 7; OP_JALR: return 8;
`endif
      default: return -1;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input int c);
    case (c)
      0: return 3'b010;
      1, 8: return 3'b011;
      2, 3: return 3'b000;
      4: return 3'b001;
      5: return 3'b100;
      default: return 3'b101;
    endcase
  endfunction

  function automatic vec_t base();
    vec_t v = '0;
    v.illegal = m_ill;
    v.bus_err = m_bus;
    v.retire_count = m_ret;
    return v;
  endfunction

  function automatic vec_t dp_vec(input int c);
    vec_t v = base();
    v.alu_op  = alu_of(c);
    v.alu_src = !(c == 0 || c == 4);
    v.wb_sel  = (c == 2) ? 2'b01 : ((c == 7 || c == 8) ? 2'b10 : 2'b00);
    return v;
  endfunction

  task automatic cyc(input vec_t v);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e, a;
      e = exp_q.pop_front();
      a.imem_req = bus.imem_req; a.dmem_req = bus.dmem_req; a.ir_write = ir_write;
      a.pc_write = pc_write; a.pc_src = PC_src; a.alu_op = alu_op; a.alu_src = alu_src;
      a.reg_write_en = reg_write_en; a.mem_read = bus.mem_read; a.mem_write = bus.mem_write;
      a.wb_sel = wb_sel; a.illegal = illegal; a.bus_err = bus_err; a.retire_count = retire_count;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL cycle t=%0t act=%h exp=%h", $time, a, e);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; branch_taken = 1'b0;
    for (int i = 0; i < n; i++) cyc('0);
    rst = 1'b0; m_ret = 0; m_ill = 0; m_bus = 0;
  endtask

  task automatic idle(input int n);
    bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
    for (int i = 0; i < n; i++) cyc(base());
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  // Drives one instruction; iw/dw = memory wait cycles, abort_mem >= 0 stops
  // after that many MEM cycles (caller then applies reset). lat = cycles used.
  task automatic do_instr(input logic [6:0] op, input int iw, input int dw,
                          input bit br, input int abort_mem, output int lat);
    vec_t v;
    int c;
    c = cls_of(op);
    lat = 0;
    opcode = op;
    for (int k = 0; ; k++) begin
      bus.imem_ready = (k == iw);
      v = base(); v.imem_req = 1'b1; v.ir_write = (k == iw);
      cyc(v); lat++;
      if (k == iw) break;
      if (k == TO) begin m_bus = 1; bus.imem_ready = 1'b0; return; end
    end
    bus.imem_ready = 1'b0;
    cyc(base()); lat++;
    if (c < 0) begin m_ill = 1; return; end
    v = dp_vec(c);
    branch_taken = br;
    if (c == 4) begin
      v.pc_write = 1'b1; v.pc_src = br;
      cyc(v); lat++; m_ret++; branch_taken = 1'b0;
      return;
    end
    cyc(v); lat++;
    branch_taken = 1'b0;
    if (c == 2 || c == 3) begin
      for (int k = 0; ; k++) begin
        if (k == abort_mem) return;
        bus.dmem_ready = (k == dw);
        v = dp_vec(c); v.dmem_req = 1'b1; v.mem_read = (c == 2); v.mem_write = (c == 3);
        v.pc_write = (k == dw) && (c == 3);
        cyc(v); lat++;
        if (k == dw) begin
          bus.dmem_ready = 1'b0;
          if (c == 3) begin m_ret++; return; end
          break;
        end
        if (k == TO) begin m_bus = 1; bus.dmem_ready = 1'b0; return; end
      end
    end
    v = dp_vec(c); v.reg_write_en = 1'b1; v.pc_write = 1'b1; v.pc_src = (c == 7 || c == 8);
    cyc(v); lat++; m_ret++;
  endtask

  initial begin
    int lat;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset(2);
    chk("rst_cnt", retire_count, 0);

    do_instr(OP_R, 0, 0, 0, -1, lat);     chk("lat_r", lat, 4);
    chk("cnt_after_r", retire_count, 1);
    do_instr(OP_I, 2, 0, 0, -1, lat);     chk("lat_i_wait2", lat, 6);
    do_instr(OP_LUI, 0, 0, 0, -1, lat);   chk("lat_lui", lat, 4);
    do_instr(OP_AUIPC, 0, 0, 0, -1, lat); chk("lat_auipc", lat, 4);
    do_instr(OP_S, 0, 0, 0, -1, lat);     chk("lat_s", lat, 4);
    do_instr(OP_L, 0, 0, 0, -1, lat);     chk("lat_l", lat, 5);
    do_instr(OP_L, 0, 3, 0, -1, lat);     chk("lat_l_dwait3", lat, 8);
    do_instr(OP_S, 1, 2, 0, -1, lat);     chk("lat_s_waits", lat, 7);
    do_instr(OP_CB, 0, 0, 1, -1, lat);    chk("lat_cb_taken", lat, 3);
    do_instr(OP_CB, 0, 0, 0, -1, lat);    chk("lat_cb_not", lat, 3);
    chk("cnt_after_10", retire_count, 10);
`ifdef CTRL_JUMP_EN
    do_instr(OP_JAL, 0, 0, 0, -1, lat);   chk("lat_jal", lat, 4);
    do_instr(OP_JALR, 0, 0, 0, -1, lat);  chk("lat_jalr", lat, 4);
    chk("cnt_after_jumps", retire_count, 12);
`else
    do_instr(OP_JAL, 0, 0, 0, -1, lat);   chk("lat_jal_trap", lat, 2);
    idle(3);
    chk("jal_illegal", illegal, 1);
`endif
    do_reset(1);

    do_instr(OP_BAD, 0, 0, 0, -1, lat);   chk("lat_bad", lat, 2);
    idle(4);
    chk("bad_illegal", illegal, 1);
    chk("bad_cnt", retire_count, 0);
    do_reset(1);

    do_instr(OP_R, 15, 0, 0, -1, lat);    chk("lat_ready_at_limit", lat, 19);
    chk("no_bus_err", bus_err, 0);
    do_instr(OP_R, 100, 0, 0, -1, lat);   chk("lat_fetch_timeout", lat, 16);
    idle(3);
    chk("fetch_bus_err", bus_err, 1);
    do_reset(1);

    do_instr(OP_L, 0, 100, 0, -1, lat);   chk("lat_mem_timeout", lat, 19);
    idle(2);
    chk("mem_bus_err", bus_err, 1);
    do_reset(1);

    do_instr(OP_R, 0, 0, 0, -1, lat);
    do_instr(OP_L, 0, 10, 0, 2, lat);
    do_reset(1);
    chk("abort_cnt", retire_count, 0);
    do_instr(OP_R, 0, 0, 0, -1, lat);     chk("lat_after_abort", lat, 4);
    chk("cnt_after_abort", retire_count, 1);

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multi-cycle successor to the single-cycle opcode decoder in the RV32I datapath. A state machine sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with instruction and data memories that may insert wait states, and times out hung memory accesses. It also traps illegal opcodes and counts retired instructions. It drives the same datapath control set, using the `ALU_OP_*` and opcode macros from defs.v.

## Interface
- OPCODE_W, 7, opcode width
- ALU_OP_W, 3, alu_op width
- MEM_TIMEOUT, 15, max wait cycles per memory request; 0 disables timeout
- CNT_W, 32, retire_count width

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- opcode  in  OPCODE_W  opcode field from the instruction register; sampled in DECODE
- branch_taken  in  1  branch comparison result from the ALU; sampled in EXEC
- imem_ready  in  1  instruction memory has returned data
- dmem_ready  in  1  data memory access is complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- ir_write  out  1  load the instruction register
- pc_write  out  1  update the PC
- PC_src  out  1  PC source: 1 = branch/jump target, 0 = pc+4
- alu_op  out  ALU_OP_W  ALU operation class
- alu_src  out  1  ALU operand B source: 1 = immediate
- reg_write_en  out  1  register file write enable
- mem_read  out  1  data memory read
- mem_write  out  1  data memory write
- wb_sel  out  2  write-back source: 00 = ALU, 01 = memory, 10 = pc+4
- illegal  out  1  sticky illegal-opcode flag
- bus_err  out  1  sticky memory-timeout flag
- retire_count  out  CNT_W  count of retired instructions

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Opcode register: loaded in DECODE; it drives alu_op, alu_src and wb_sel in EXEC, MEM and WB.
- ALU class per opcode:
  - R → `ALU_OP_R_type`
  - I → `ALU_OP_I_type`
  - L/S → `ALU_OP_LW_SW_type`
  - CB → `ALU_OP_CB_type`
  - LUI → `ALU_OP_LUI_type`
  - AUIPC → `ALU_OP_AUIPC_type`
  - JAL → `ALU_OP_AUIPC_type`
  - JALR → `ALU_OP_I_type`
- alu_src = 1 for every class except R and CB.
- FETCH:
  - imem_req = 1.
  - When imem_ready is high, ir_write = 1 that cycle and the FSM goes to DECODE.
- DECODE:
  - One cycle.
  - An unknown opcode goes to TRAP and sets illegal.
  - Any other opcode goes to EXEC.
- EXEC, by class:
  - CB: pc_write = 1, PC_src = branch_taken, retire, then FETCH.
  - L/S: go to MEM.
  - All other classes: go to WB.
- MEM:
  - dmem_req = 1, plus mem_read = 1 for L or mem_write = 1 for S, all held until dmem_ready.
  - On dmem_ready: L goes to WB; S sets pc_write = 1, retires, and goes to FETCH.
- WB:
  - reg_write_en = 1 and pc_write = 1, retire, then FETCH.
  - wb_sel = 01 for L, 10 for JAL/JALR, 00 otherwise.
  - PC_src = 1 for JAL/JALR, 0 otherwise.
- Retire: retire_count increments by 1 and wraps from 2^CNT_W−1 to 0.
- Timeout:
  - The wait counter clears on entering FETCH or MEM and increments on each cycle the ready input is low.
  - If the counter reaches MEM_TIMEOUT with ready still low, go to TRAP and set bus_err.
  - If ready arrives in the same cycle the counter reaches MEM_TIMEOUT, ready wins.
- TRAP:
  - All control outputs are 0.
  - illegal and bus_err hold their values.
  - Only rst exits TRAP.

## Timing
- While rst is high: the next state is FETCH; every output is 0, including imem_req, the flags and retire_count.
- First fetch: imem_req = 1 on the first cycle after rst falls.
- Control outputs are combinational from the state and opcode register; no output is asserted outside the state that owns it.
- Latency with zero wait states (imem_ready/dmem_ready high on the first request cycle):
  - CB: 3 cycles
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles
  - S: 4 cycles
  - L: 5 cycles
- Each wait cycle adds 1 to the latency.
- Reset mid-instruction: the instruction is aborted, the request is dropped in the same cycle, and no retire occurs.
- pc_write pulses exactly once per retired instruction.

## Configuration
- CTRL_JUMP_EN defined: JAL and JALR are decoded as described above.
- CTRL_JUMP_EN undefined: JAL and JALR are treated as illegal, so DECODE goes to TRAP with illegal = 1.

## Test plan
- R-type, zero-wait memory: imem_req in cycle 1, reg_write_en with wb_sel = 00 in cycle 4, retire_count = 1.
- Load with dmem_ready delayed 3 cycles: mem_read held for 4 cycles, WB with wb_sel = 01, total latency 8 cycles.
- CB: branch_taken = 1 gives pc_write = 1 and PC_src = 1 in EXEC; branch_taken = 0 gives PC_src = 0; both retire in 3 cycles.
- Timeout:
  - imem_ready held low: bus_err rises after 15 wait cycles and the FSM stays in TRAP until rst.
  - imem_ready rising on the 15th wait cycle: no trap.
- Opcode 7'b1111111 gives illegal = 1 after DECODE. JAL gives wb_sel = 10 with CTRL_JUMP_EN defined, and illegal = 1 without it.
- Reset asserted during a MEM wait: dmem_req drops in the same cycle, retire_count = 0, and the FSM restarts in FETCH.
